// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-requester round-robin one-hot arbiter.
package arb_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // The argument is always zero or one-hot, so OR-ing the set bit indices yields the owner.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate right by ptr, isolate the lowest set bit, rotate back.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic             found
);

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] first;

  assign cand  = req & ~mask;
  assign found = |cand;

  // Index arithmetic is IDX_W bits wide, so the wrap 7->0 falls out of the truncation.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rot[gi]    = cand[IDX_W'(gi) + ptr];
    assign onehot[gi] = first[IDX_W'(gi) - ptr];
  end

  assign first = rot & (~rot + N_REQ'(1));

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and zero-bubble handoff.
// Optional tenure limit enabled by defining ARB_HOLD_LIMIT_EN (limit set by MAX_HOLD).
module rr_onehot_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             grantValid,
  output logic             grantChange
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("MAX_HOLD must lie in 2..255");
  end

  state_t           state_reg;
  logic [N_REQ-1:0] grant_reg;
  logic             grant_valid_reg;
  logic             grant_change_reg;
  logic [IDX_W-1:0] ptr_reg;

  logic [IDX_W-1:0] owner_idx;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_mask;
  logic [N_REQ-1:0] pick_onehot;
  logic             pick_found;
  logic             owner_active;
  logic             preempt;
  logic             release_now;

  assign owner_idx    = onehot_to_idx(grant_reg);
  assign next_ptr     = owner_idx + IDX_W'(1);
  assign owner_active = (state_reg == GRANT);

  // While a grant is held the picker already looks at the post-release window, so the
  // handoff winner is ready on the same edge the owner lets go.
  assign pick_ptr     = owner_active ? next_ptr : ptr_reg;
  assign pick_mask    = owner_active ? grant_reg : '0;
  assign release_now  = owner_active && (!(|(req & grant_reg)) || preempt);

  rr_pick u_pick (
    .req    (req),
    .mask   (pick_mask),
    .ptr    (pick_ptr),
    .onehot (pick_onehot),
    .found  (pick_found)
  );

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_reg;

  assign preempt = owner_active && (hold_cnt_reg == HOLD_LAST) && (|(req & ~grant_reg));

  // Saturates at HOLD_LAST so a lone owner is preempted as soon as anyone else asks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_reg <= '0;
    end else if (owner_active && !release_now) begin
      if (hold_cnt_reg != HOLD_LAST) hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
    end else begin
      hold_cnt_reg <= '0;
    end
  end
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      grant_reg        <= '0;
      grant_valid_reg  <= 1'b0;
      grant_change_reg <= 1'b0;
      ptr_reg          <= '0;
    end else begin
      grant_change_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg        <= pick_onehot;
            grant_valid_reg  <= 1'b1;
            grant_change_reg <= 1'b1;
            state_reg        <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr_reg <= next_ptr;
            if (pick_found) begin
              grant_reg        <= pick_onehot;
              grant_valid_reg  <= 1'b1;
              grant_change_reg <= 1'b1;
            end else begin
              grant_reg       <= '0;
              grant_valid_reg <= 1'b0;
              state_reg       <= IDLE;
            end
          end
        end
        default: begin
          grant_reg       <= '0;
          grant_valid_reg <= 1'b0;
          state_reg       <= IDLE;
        end
      endcase
    end
  end

  assign grant       = grant_reg;
  assign grantValid  = grant_valid_reg;
  assign grantChange = grant_change_reg;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter: vector table plus hand-written reset and hold-limit sequences.
module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic       grantValid;
  logic       grantChange;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] req;
    logic [7:0] grant;
    logic       valid;
    logic       change;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  rr_onehot_arbiter #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grantValid  (grantValid),
    .grantChange (grantChange)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive req, let one rising edge pass, sample 1ns later, return at the next negedge.
  task automatic step(input logic [7:0] r, input logic [7:0] g, input logic v, input logic c,
                      input string tag);
    req = r;
    @(posedge clk);
    #1;
    $display("txn %-20s req=%02h grant=%02h valid=%0b change=%0b", tag, r, grant, grantValid, grantChange);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".valid"}, 32'(grantValid), 32'(v));
    check({tag, ".change"}, 32'(grantChange), 32'(c));
    @(negedge clk);
  endtask

  task automatic add(input logic [7:0] r, input logic [7:0] g, input logic v, input logic c,
                     input string tag);
    vec_t e;
    e.req = r; e.grant = g; e.valid = v; e.change = c; e.tag = tag;
    vecs.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Grant must be zero or one-hot and grantValid must track it on every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (!$onehot0(grant) || (grantValid !== (|grant))) begin
        errors++;
        $display("FAIL onehot_invariant actual grant=%02h valid=%0b required onehot0 with valid=|grant",
                 grant, grantValid);
      end
    end
  end

  initial begin
    logic [7:0] eg;
    logic       ec;

    // Fairness rotation from reset: each owner keeps 3 cycles, then drops its bit for one.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] drop;
      drop = (k == 0) ? 8'hFF : (8'hFF & ~(8'h01 << (k - 1)));
      add(drop, 8'h01 << k, 1'b1, 1'b1, $sformatf("fair_grant%0d", k));
      add(8'hFF, 8'h01 << k, 1'b1, 1'b0, $sformatf("fair_hold%0d_a", k));
      add(8'hFF, 8'h01 << k, 1'b1, 1'b0, $sformatf("fair_hold%0d_b", k));
    end
    add(8'h7F, 8'h01, 1'b1, 1'b1, "fair_wrap");
    add(8'h80, 8'h80, 1'b1, 1'b1, "to_owner7");
    add(8'h00, 8'h00, 1'b0, 1'b0, "idle_ptr0");
    add(8'h24, 8'h04, 1'b1, 1'b1, "hand_first");
    add(8'h24, 8'h04, 1'b1, 1'b0, "hand_hold");
    add(8'h20, 8'h20, 1'b1, 1'b1, "handoff_no_bubble");
    add(8'h00, 8'h00, 1'b0, 1'b0, "release_idle");
    add(8'h41, 8'h40, 1'b1, 1'b1, "ptr6_pick");
    add(8'h01, 8'h01, 1'b1, 1'b1, "wrap_6_to_0");
    add(8'h80, 8'h80, 1'b1, 1'b1, "pick_7");
    add(8'h01, 8'h01, 1'b1, 1'b1, "wrap_7_to_0");
    add(8'h00, 8'h00, 1'b0, 1'b0, "idle_ptr1");
    add(8'h06, 8'h02, 1'b1, 1'b1, "pick_from1");
    add(8'h0A, 8'h02, 1'b1, 1'b0, "nonowner_ignored");
    add(8'h00, 8'h00, 1'b0, 1'b0, "dropped_not_latched");

    // Reset held with all requests active.
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("reset.grant", 32'(grant), 32'h0);
    check("reset.valid", 32'(grantValid), 32'h0);
    check("reset.change", 32'(grantChange), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) step(vecs[i].req, vecs[i].grant, vecs[i].valid, vecs[i].change, vecs[i].tag);

    // Asynchronous reset mid-tenure, then restart from ptr=0.
    step(8'h10, 8'h10, 1'b1, 1'b1, "grant_owner4");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.grant", 32'(grant), 32'h0);
    check("async_rst.valid", 32'(grantValid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h11, 8'h01, 1'b1, 1'b1, "after_rst_ptr0");

    // Two contenders held continuously: tenure limit alternates them, otherwise owner 0 keeps it.
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
`ifdef ARB_HOLD_LIMIT_EN
      eg = (((i / 4) % 2) == 0) ? 8'h01 : 8'h02;
      ec = ((i % 4) == 0);
`else
      eg = 8'h01;
      ec = (i == 0);
`endif
      step(8'h03, eg, 1'b1, ec, $sformatf("hold_pair%0d", i));
    end

    // Lone requester is never preempted; a late contender takes over only with the limit enabled.
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      step(8'h01, 8'h01, 1'b1, (i == 0), $sformatf("hold_alone%0d", i));
    end
`ifdef ARB_HOLD_LIMIT_EN
    step(8'h03, 8'h02, 1'b1, 1'b1, "late_contender");
`else
    step(8'h03, 8'h01, 1'b1, 1'b0, "late_contender");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
